// File: rtl/core_defines.sv
// Shared core definitions: data width, reset vector, NOP encoding and the fetch-queue entry.
package core_defines;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; head entry read from registered storage.
module fetch_queue
  import core_defines::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH for free.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch-stage front end: owns the PC, captures icache words into fetch_queue, hands {pc, instr, pc+4} to decode.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall event counters.
module fetch_unit
  import core_defines::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] icache_addr,
  input  logic [31:0] icache_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [31:0]   pc;
  logic          push;
  logic          pop;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  fetch_entry_t  q_din;
  fetch_entry_t  q_head;

  // Handshake: decode takes the head when id_valid & id_ready in the same cycle;
  // id_valid never depends on id_ready. A pop during a redirect is still a
  // completed transfer from decode's point of view; the flush then drops the rest.
  assign pop  = id_valid & id_ready;
  assign push = ~redirect_valid & (~q_full | pop);

  assign icache_addr = pc;
  assign q_din       = '{pc: pc, instr: icache_instr};

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc <= next_pc(pc);
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  // Outputs read as zero while the queue is empty so stale storage never leaks.
  assign id_valid = (q_count != '0);
  assign id_pc    = q_empty ? 32'h0 : q_head.pc;
  assign id_instr = q_empty ? 32'h0 : q_head.instr;
  assign id_pc4   = q_empty ? 32'h0 : next_pc(q_head.pc);

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if (q_full && !pop && !redirect_valid) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table on a RESET_PC=0 instance plus a wrap sequence on RESET_PC=FFFF_FFFC.
module tb_fetch_unit;
  import core_defines::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // instance A (RESET_PC = 0)
  logic        reset, redirect_valid, id_ready;
  logic [31:0] redirect_pc, icache_addr, icache_instr;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc4;
  // instance B (RESET_PC = FFFF_FFFC)
  logic        b_reset, b_redirect_valid, b_id_ready;
  logic [31:0] b_redirect_pc, b_icache_addr, b_icache_instr;
  logic        b_id_valid;
  logic [31:0] b_id_instr, b_id_pc, b_id_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, b_perf_fetched, b_perf_stall;
`endif

  // icache stub: three preloaded words, otherwise an address-derived pattern
  function automatic logic [31:0] icache_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h3e80_0093;
      32'h4:   return 32'h7d00_8113;
      32'h8:   return 32'hc181_0193;
      default: return {~a[31:2], 2'b11};
    endcase
  endfunction

  assign icache_instr   = icache_word(icache_addr);
  assign b_icache_instr = icache_word(b_icache_addr);

  fetch_unit #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .icache_addr(icache_addr), .icache_instr(icache_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FQ_DEPTH(2)) dut_b (
    .clock(clock), .reset(b_reset), .icache_addr(b_icache_addr), .icache_instr(b_icache_instr),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc), .id_ready(b_id_ready),
    .id_valid(b_id_valid), .id_instr(b_id_instr), .id_pc(b_id_pc), .id_pc4(b_id_pc4)
`ifdef FETCH_PERF_EN
    , .perf_fetched(b_perf_fetched), .perf_stall(b_perf_stall)
`endif
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Each step: check the current outputs, then drive inputs for the next rising edge.
  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        chkp;
    logic [31:0] efetched;
    logic [31:0] estall;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  initial begin
    // rst rv  rpc          rdy  ev  epc          eaddr        chkp fetched stall
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,   1'b1, 32'd0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   32'h4,   1'b0, 32'd0, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   32'h8,   1'b0, 32'd0, 32'd0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   32'hC,   1'b0, 32'd0, 32'd0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   1'b1, 32'd0, 32'd0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h4,   1'b0, 32'd0, 32'd0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h8,   1'b0, 32'd0, 32'd0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   32'h8,   1'b0, 32'd0, 32'd0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   32'hC,   1'b0, 32'd0, 32'd0};
    vecs[9]  = '{1'b0, 1'b1, 32'h13,  1'b0, 1'b1, 32'h8,   32'h10,  1'b1, 32'd4, 32'd1};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h10,  1'b0, 32'd0, 32'd0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10,  32'h14,  1'b0, 32'd0, 32'd0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  32'h18,  1'b0, 32'd0, 32'd0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h14,  32'h1C,  1'b0, 32'd0, 32'd0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h14,  32'h1C,  1'b0, 32'd0, 32'd0};
    vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h18,  32'h20,  1'b0, 32'd0, 32'd0};
    vecs[16] = '{1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h18,  32'h20,  1'b1, 32'd8, 32'd3};
    vecs[17] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h100, 1'b0, 32'd0, 32'd0};
    vecs[18] = '{1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h100, 32'h104, 1'b0, 32'd0, 32'd0};
    vecs[19] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,   1'b1, 32'd0, 32'd0};
    vecs[20] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   32'h4,   1'b1, 32'd1, 32'd0};

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    b_reset = 1'b1; b_redirect_valid = 1'b0; b_redirect_pc = 32'h0; b_id_ready = 1'b0;
    repeat (3) @(posedge clock);

    for (int i = 0; i < NV; i++) begin
      logic [31:0] e_pc, e_instr, e_pc4;
      @(negedge clock);
      e_pc    = vecs[i].ev ? vecs[i].epc : 32'h0;
      e_instr = vecs[i].ev ? icache_word(vecs[i].epc) : 32'h0;
      e_pc4   = vecs[i].ev ? vecs[i].epc + 32'd4 : 32'h0;
      chk($sformatf("v%0d icache_addr", i), icache_addr, vecs[i].eaddr);
      chk($sformatf("v%0d id_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].ev});
      chk($sformatf("v%0d id_pc", i), id_pc, e_pc);
      chk($sformatf("v%0d id_instr", i), id_instr, e_instr);
      chk($sformatf("v%0d id_pc4", i), id_pc4, e_pc4);
`ifdef FETCH_PERF_EN
      if (vecs[i].chkp) begin
        chk($sformatf("v%0d perf_fetched", i), perf_fetched, vecs[i].efetched);
        chk($sformatf("v%0d perf_stall", i), perf_stall, vecs[i].estall);
      end
`endif
      reset          = vecs[i].rst;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      id_ready       = vecs[i].rdy;
    end

    // PC wrap sequence on instance B, held in reset until now
    @(negedge clock);
    chk("b reset id_valid", {31'b0, b_id_valid}, 32'h0);
    chk("b reset icache_addr", b_icache_addr, 32'hFFFF_FFFC);
    chk("b reset id_pc", b_id_pc, 32'h0);
`ifdef FETCH_PERF_EN
    chk("b reset perf_fetched", b_perf_fetched, 32'h0);
    chk("b reset perf_stall", b_perf_stall, 32'h0);
`endif
    b_reset = 1'b0; b_id_ready = 1'b1;
    @(negedge clock);
    chk("b first id_valid", {31'b0, b_id_valid}, 32'h1);
    chk("b first id_pc", b_id_pc, 32'hFFFF_FFFC);
    chk("b first id_pc4", b_id_pc4, 32'h0);
    chk("b first id_instr", b_id_instr, icache_word(32'hFFFF_FFFC));
    chk("b first icache_addr", b_icache_addr, 32'h0);
    @(negedge clock);
    chk("b second id_pc", b_id_pc, 32'h0);
    chk("b second id_pc4", b_id_pc4, 32'h4);
    chk("b second id_instr", b_id_instr, 32'h3e80_0093);
    chk("b second icache_addr", b_icache_addr, 32'h4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch-stage front end.
- Owns the architectural PC and drives the combinational icache address.
- Captures the returned instruction into a small fetch queue.
- Presents {pc, instr, pc+4} to decode with a valid/ready handshake; handles redirects from execute (branch/jump) by flushing and re-steering.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FQ_DEPTH, 2, fetch-queue entries; power of two, ≥2.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- icache_addr  out  32  byte address to icache; equals pc register (combinational from pc).
- icache_instr  in  32  instruction word returned combinationally for icache_addr.
- redirect_valid  in  1  execute-stage redirect request.
- redirect_pc  in  32  redirect target.
- id_ready  in  1  decode accepts head entry this cycle.
- id_valid  out  1  queue non-empty.
- id_instr  out  32  head instruction.
- id_pc  out  32  head PC.
- id_pc4  out  32  head PC + 4, mod 2^32.

Behaviour:
- Reset: synchronous, active-high; sampled on clock rising edge.
  - pc <= RESET_PC; queue emptied (rd/wr ptr = 0, count = 0).
  - id_valid = 0; id_instr/id_pc/id_pc4 = 0 while empty.
  - Reset dominates redirect and all handshakes, including mid-stream.
- pop = id_valid & id_ready.
- push = ~redirect_valid & (count < FQ_DEPTH | pop).
  - Push when full is allowed only if a pop occurs in the same cycle; count is unchanged.
- On push: the entry {pc, icache_instr} is written at wr_ptr and pc <= pc + 4.
  - 32-bit wrap: 32'hFFFF_FFFC -> 32'h0000_0000.
- No push (full, no pop): pc holds; icache_addr stable.
- Redirect (redirect_valid = 1):
  - Queue flushed: count <= 0, pointers to 0; id_valid = 0 next cycle.
  - pc <= {redirect_pc[31:2], 2'b00}, i.e. low bits forced to zero.
  - No push that cycle.
  - A pop in the same cycle is still reported to decode (id_valid was 1) but the entry is discarded by the flush.
- Latency:
  - Instruction at pc appears on id_* one cycle after pc drives icache_addr.
  - First id_valid = 1 is the first cycle after reset deasserts +1.
  - After a redirect, the target instruction is valid 2 cycles after redirect_valid is sampled.
- Throughput: 1 instr/cycle sustained with id_ready = 1.
- id_* outputs come from registered queue storage (head entry); no combinational path from icache_instr to id_instr.
- Pointers wrap modulo FQ_DEPTH.
- Count range 0..FQ_DEPTH; never exceeds.
- No explicit FSM: state is pc + queue occupancy.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32) and perf_stall (32).
  - perf_fetched counts pushes.
  - perf_stall counts cycles with count == FQ_DEPTH & ~pop & ~redirect_valid.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package core_defines:
  - XLEN = 32.
  - default RESET_PC.
  - INSTR_NOP = 32'h0000_0013.
  - fetch-entry struct/typedef {pc[31:0], instr[31:0]}.
- One natural sub-module, fetch_queue: synchronous FIFO.
  - Ports: push, pop, flush, data in/out, count, full/empty.
- fetch_unit holds the PC logic and instantiates fetch_queue.

Test Plan:
- Reset then id_ready = 1, icache preloaded [0] = 32'h3e800093, [1] = 32'h7d008113, [2] = 32'hc1810193 -> consecutive cycles show id_pc 0, 4, 8 with those instrs; id_pc4 4, 8, 12.
- id_ready = 0 from reset -> after 2 pushes id_valid = 1, icache_addr holds 32'h8, id_pc stays 0. Raise id_ready -> pcs 0, 4, 8 delivered in order, no loss or duplication.
- Redirect_valid with redirect_pc = 32'h0000_0013 while queue holds 2 entries -> next cycle id_valid = 0, icache_addr = 32'h10. Following cycle id_pc = 32'h10.
- Full queue with simultaneous pop, id_ready toggling each cycle -> count never exceeds 2; PC sequence on id_pc strictly +4.
- RESET_PC = 32'hFFFF_FFFC -> id_pc FFFF_FFFC then 0000_0000; id_pc4 of the first entry = 0.
- Assert reset mid-stream with redirect_valid = 1 -> next cycle pc = RESET_PC, id_valid = 0. With FETCH_PERF_EN defined, perf counters = 0.
